// File: rtl/innerproduct_pkg.sv
// Shared definitions for the inner-product MAC slice.
//   - DEF_DW / DEF_NFEAT : default data width and theta count
//   - state_t            : MAC controller states
package innerproduct_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_NFEAT = 41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/innerproduct_mac_if.sv
// Bus bundle for innerproduct_mac: theta write port, feature stream in,
// inner-product result out.
//   theta_we/theta_addr/theta_wdata : theta register write
//   x_valid/x_ready/x_data/x_last   : feature beat stream (into the MAC)
//   h_valid/h_ready/h_data/err_len  : result stream and length-error pulse
// slave = MAC side, master = driver side.
interface innerproduct_mac_if
  import innerproduct_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NFEAT = DEF_NFEAT
) ();

  localparam int AW = $clog2(NFEAT);

  logic          theta_we;
  logic [AW-1:0] theta_addr;
  logic [DW-1:0] theta_wdata;

  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          x_last;

  logic          h_valid;
  logic          h_ready;
  logic [DW-1:0] h_data;
  logic          err_len;

  modport slave (
    input  theta_we, theta_addr, theta_wdata,
    input  x_valid, x_data, x_last,
    output x_ready,
    output h_valid, h_data, err_len,
    input  h_ready
  );

  modport master (
    output theta_we, theta_addr, theta_wdata,
    output x_valid, x_data, x_last,
    input  x_ready,
    input  h_valid, h_data, err_len,
    output h_ready
  );

endinterface

// File: rtl/innerproduct_mac_theta_regfile.sv
// theta_regfile: NFEAT x DW coefficient store, one synchronous write port,
// all entries visible in parallel. Synchronous active-high reset clears all.
//   clk, rst  : clock / sync reset
//   i_we      : write strobe
//   i_addr    : write index (values >= NFEAT are ignored)
//   i_wdata   : write value
//   o_theta   : all NFEAT entries
module theta_regfile #(
  parameter int DW    = 32,
  parameter int NFEAT = 41
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(NFEAT)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_theta [NFEAT]
);

  localparam int AW = $clog2(NFEAT);

  logic [DW-1:0] r_theta [NFEAT];

  // Address decode only matches valid entries, so out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NFEAT; k++) r_theta[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NFEAT; k++) begin
        if (i_we && (i_addr == AW'(k))) r_theta[k] <= i_wdata;
      end
    end
  end

  assign o_theta = r_theta;

endmodule

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: streams feature beats x[i] and computes
//   h = theta[0] + sum_i x[i]*theta[i+1]   (terms masked by FEAT_MASK)
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : innerproduct_mac_if.slave (theta write, x stream, h stream, err_len)
// Build option INNERPROD_SAT_EN: full-width products and a wide accumulator
// with h_data saturated to the signed DW range. Without it, all arithmetic
// wraps at DW bits. Latency is identical in both builds.
module innerproduct_mac
  import innerproduct_pkg::*;
#(
  parameter int               DW        = DEF_DW,
  parameter int               NFEAT     = DEF_NFEAT,
  parameter logic [NFEAT-1:0] FEAT_MASK = '1
) (
  input logic                clk,
  input logic                rst,
  innerproduct_mac_if.slave  bus
);

  localparam int IW = $clog2(NFEAT);

`ifdef INNERPROD_SAT_EN
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(NFEAT);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'($signed({1'b0, {(DW-1){1'b1}}}));
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'($signed({1'b1, {(DW-1){1'b0}}}));

  function automatic logic [DW-1:0] f_result(input logic signed [ACCW-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return a[DW-1:0];
  endfunction
`else
  localparam int PW   = DW;
  localparam int ACCW = DW;

  function automatic logic [DW-1:0] f_result(input logic signed [ACCW-1:0] a);
    return a;
  endfunction
`endif

  logic [DW-1:0]           w_theta [NFEAT];

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IW-1:0]           r_idx;
  logic signed [ACCW-1:0]  r_acc;
  logic [DW-1:0]           r_h_data;
  logic                    r_err;

  logic                    w_fire;
  logic                    w_x_ready;
  logic                    w_h_valid;
  logic [IW-1:0]           w_beat_idx;
  logic [IW-1:0]           w_sel;
  logic [DW-1:0]           w_theta_sel;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACCW-1:0]  w_term;
  logic signed [ACCW-1:0]  w_base;
  logic signed [ACCW-1:0]  w_acc_next;
  logic                    w_last_idx;
  logic                    w_end;

  theta_regfile #(
    .DW    (DW),
    .NFEAT (NFEAT)
  ) u_theta (
    .clk     (clk),
    .rst     (rst),
    .i_we    (bus.theta_we),
    .i_addr  (bus.theta_addr),
    .i_wdata (bus.theta_wdata),
    .o_theta (w_theta)
  );

  // Ready is decoded from state directly so the fire term has no loop
  // through the FSM output process.
  assign w_fire = bus.x_valid && (r_state != OUT);

  // A beat in IDLE is always beat 0 and seeds the accumulator with the bias.
  assign w_beat_idx  = (r_state == IDLE) ? '0 : r_idx;
  assign w_sel       = w_beat_idx + IW'(1);
  assign w_theta_sel = w_theta[w_sel];
  assign w_prod      = PW'($signed(bus.x_data)) * PW'($signed(w_theta_sel));
  assign w_term      = FEAT_MASK[w_sel] ? ACCW'(w_prod) : '0;
  assign w_base      = (r_state == IDLE) ? ACCW'($signed(w_theta[0])) : r_acc;
  assign w_acc_next  = w_base + w_term;
  assign w_last_idx  = (w_beat_idx == IW'(NFEAT - 2));
  assign w_end       = bus.x_last || w_last_idx;

  always_comb begin
    w_state_next = r_state;
    w_x_ready    = 1'b0;
    w_h_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_x_ready = 1'b1;
        if (w_fire) w_state_next = w_end ? OUT : ACC;
      end
      ACC: begin
        w_x_ready = 1'b1;
        if (w_fire && w_end) w_state_next = OUT;
      end
      OUT: begin
        w_h_valid = 1'b1;
        if (bus.h_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_h_data <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= 1'b0;
      if (w_fire) begin
        r_acc <= w_acc_next;
        r_idx <= w_beat_idx + IW'(1);
        if (w_end) begin
          r_idx    <= '0;
          r_h_data <= f_result(w_acc_next);
          // Length error: x_last and the final index must coincide.
          r_err    <= bus.x_last ^ w_last_idx;
        end
      end
    end
  end

  assign bus.x_ready = w_x_ready;
  assign bus.h_valid = w_h_valid;
  assign bus.h_data  = r_h_data;
  assign bus.err_len = r_err;

endmodule
